mem_port_arbiter: RTL
=====================

Name: mem_port_arbiter

Overview:
- Shares the single-port unified memory between the instruction-fetch path and the load/store path of the multi-cycle CPU.
- The fetch side supplies the instruction word behind IR_buf / W_IR_valid. The load/store side serves LDR/STR sequencing from the controller FSM.
- Load/store has fixed priority. A streak counter prevents fetch starvation.
- Transfers are fully sequenced through a req/ack handshake on both sides.

Parameters:
- ADDR_W, 32, address width.
- DATA_W, 32, data width.
- MAX_LS_STREAK, 4, consecutive load/store grants allowed while fetch waits (range 1..15).
- TIMEOUT, 16, BUSY cycles without mem_ack before abort (ARB_TIMEOUT_EN only; range 2..255).

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- if_req  in  1  fetch request, level.
- if_addr  in  ADDR_W  fetch address.
- if_ack  out  1  one-cycle fetch completion pulse.
- if_rdata  out  DATA_W  fetched word; valid while if_ack=1, then held.
- ls_req  in  1  load/store request, level.
- ls_we  in  1  1 = store.
- ls_addr  in  ADDR_W  load/store address.
- ls_wdata  in  DATA_W  store data.
- ls_ack  out  1  one-cycle load/store completion pulse.
- ls_rdata  out  DATA_W  load data; valid while ls_ack=1, then held.
- mem_req  out  1  memory request, held until mem_ack.
- mem_we  out  1  memory write enable.
- mem_addr  out  ADDR_W  memory address.
- mem_wdata  out  DATA_W  memory write data.
- mem_ack  in  1  memory completion, one cycle.
- mem_rdata  in  DATA_W  memory read data; valid with mem_ack.
- arb_busy  out  1  1 when state is not IDLE.
- arb_owner  out  1  current or last grant: 0 = fetch, 1 = load/store.
- bus_err  out  1  one-cycle timeout pulse; tied 0 without ARB_TIMEOUT_EN.

Behaviour:
- States:
  - IDLE: evaluate requests.
  - BUSY: mem_req=1, waiting for mem_ack.
  - DONE: pulse the owner's ack.
  - All outputs are registered.
- Reset (asynchronous, any state, including mid-transfer):
  - State goes to IDLE.
  - mem_req, mem_we, if_ack, ls_ack, bus_err, arb_busy and arb_owner go to 0.
  - mem_addr, mem_wdata, if_rdata and ls_rdata go to 0.
  - The streak counter and the timeout counter go to 0.
  - An interrupted transfer is dropped and never acked.
- IDLE arbitration, in cycle T:
  - ls_req only: grant LS.
  - if_req only: grant IF.
  - Both asserted: grant LS, unless streak == MAX_LS_STREAK, in which case grant IF.
  - Neither asserted: stay in IDLE.
- On grant:
  - addr, we and wdata are latched into mem_addr, mem_we and mem_wdata.
  - Fetch grants force mem_we=0.
  - In cycle T+1: state=BUSY, mem_req=1, arb_busy=1, arb_owner updated.
- Streak counter update, at each grant:
  - IF grant: clear to 0.
  - LS grant with if_req=1: increment, saturating at MAX_LS_STREAK.
  - LS grant with if_req=0: clear to 0.
- BUSY:
  - mem_req and the latched address/data remain stable until the cycle mem_ack=1.
  - Requester inputs are ignored in this state.
- mem_ack=1 in BUSY, cycle Tk:
  - Next cycle: state=DONE, mem_req=0.
  - The owner's ack=1 and the owner's rdata = mem_rdata; rdata is 0 for a store.
- DONE:
  - Lasts exactly one cycle, then IDLE; arb_busy=0 in IDLE.
  - Minimum request-to-ack latency is 2 cycles (mem_ack in the first BUSY cycle).
  - Minimum back-to-back period is 3 cycles.
- Requester rule:
  - A requester samples ack at the clock edge.
  - req still high in the IDLE cycle after DONE means a new transfer.
  - req must be held, with stable addr/data, until ack.
- mem_ack while in IDLE or DONE is ignored.
- The non-owner's ack stays 0 throughout a transfer.

Optional Feature:
- Macro ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entering BUSY and increments each BUSY cycle without mem_ack.
  - When the counter reaches TIMEOUT, next cycle: state=DONE, mem_req=0, owner ack=1, owner rdata=0, bus_err=1 for one cycle.
  - The streak counter is unaffected.
  - mem_ack in the same cycle the counter reaches TIMEOUT wins: normal completion, bus_err=0.
- Undefined:
  - No counter; BUSY waits indefinitely.
  - bus_err is constant 0.

Test Plan:
- Single fetch: if_req=1, if_addr=0x100, memory acks in the first BUSY cycle with 0xE3A01005 -> mem_req high for 1 cycle, mem_addr=0x100, mem_we=0; if_ack pulses 2 cycles after the request, if_rdata=0xE3A01005; ls_ack stays 0.
- Store: ls_req=1, ls_we=1, ls_addr=0x200, ls_wdata=0xDEADBEEF, memory acks after 3 BUSY cycles -> mem_req/mem_we/mem_addr/mem_wdata stable all 3 cycles; ls_ack one cycle with ls_rdata=0.
- Contention: if_req and ls_req both held high continuously, MAX_LS_STREAK=4 -> grant order LS, LS, LS, LS, IF, LS, LS, LS, LS, IF.
- Reset mid-transfer: rst asserted in the 2nd BUSY cycle of a load -> mem_req=0 immediately, without waiting for clk; no ls_ack; after release, IDLE with streak=0.
- Timeout (ARB_TIMEOUT_EN, TIMEOUT=16): fetch with mem_ack never asserted -> mem_req drops after 16 BUSY cycles; if_ack=1, if_rdata=0, bus_err=1 for one cycle; next request is served normally.
- Late ack tie (ARB_TIMEOUT_EN): mem_ack=1 in the cycle the counter reaches TIMEOUT, mem_rdata=0x12345678 -> normal completion with rdata=0x12345678, bus_err=0.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter between instruction fetch and load/store, with
// load/store priority and a fetch anti-starvation streak. Optional BUSY timeout: ARB_TIMEOUT_EN.
module mem_port_arbiter #(
  parameter int ADDR_W        = 32,
  parameter int DATA_W        = 32,
  parameter int MAX_LS_STREAK = 4,
  parameter int TIMEOUT       = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_ack,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_ack,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic              mem_ack,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              arb_busy,
  output logic              arb_owner,
  output logic              bus_err
);

  typedef enum logic [1:0] {IDLE = 2'd0, BUSY = 2'd1, DONE = 2'd2} state_t;

  localparam logic [3:0] STREAK_MAX = 4'(MAX_LS_STREAK);

  state_t              state_q;
  logic [3:0]          streak_q;
  logic                mem_req_q, mem_we_q, if_ack_q, ls_ack_q, arb_busy_q, arb_owner_q;
  logic [ADDR_W-1:0]   mem_addr_q;
  logic [DATA_W-1:0]   mem_wdata_q, if_rdata_q, ls_rdata_q;
  logic                grant_ls_s;
  logic [3:0]          streak_inc_s;

`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT - 1);
  logic [7:0] tmo_q;
  logic       bus_err_q;
  assign bus_err = bus_err_q;
`else
  logic unused_tmo_s;
  assign unused_tmo_s = ^8'(TIMEOUT);
  assign bus_err      = 1'b0;
`endif

  // Fetch wins a contested slot only once load/store has used up its streak.
  always_comb begin
    grant_ls_s = 1'b0;
    if (ls_req && !(if_req && (streak_q == STREAK_MAX))) begin
      grant_ls_s = 1'b1;
    end else begin
      grant_ls_s = 1'b0;
    end
  end

  always_comb begin
    streak_inc_s = streak_q;
    if (streak_q == STREAK_MAX) begin
      streak_inc_s = streak_q;
    end else begin
      streak_inc_s = streak_q + 4'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      streak_q    <= 4'd0;
      mem_req_q   <= 1'b0;
      mem_we_q    <= 1'b0;
      mem_addr_q  <= {ADDR_W{1'b0}};
      mem_wdata_q <= {DATA_W{1'b0}};
      if_ack_q    <= 1'b0;
      ls_ack_q    <= 1'b0;
      if_rdata_q  <= {DATA_W{1'b0}};
      ls_rdata_q  <= {DATA_W{1'b0}};
      arb_busy_q  <= 1'b0;
      arb_owner_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_q       <= 8'd0;
      bus_err_q   <= 1'b0;
`endif
    end else begin
      case (state_q)
        IDLE: begin
          if (ls_req || if_req) begin
            state_q    <= BUSY;
            mem_req_q  <= 1'b1;
            arb_busy_q <= 1'b1;
`ifdef ARB_TIMEOUT_EN
            tmo_q      <= 8'd0;
`endif
            if (grant_ls_s) begin
              arb_owner_q <= 1'b1;
              mem_we_q    <= ls_we;
              mem_addr_q  <= ls_addr;
              mem_wdata_q <= ls_wdata;
              streak_q    <= if_req ? streak_inc_s : 4'd0;
            end else begin
              arb_owner_q <= 1'b0;
              mem_we_q    <= 1'b0;
              mem_addr_q  <= if_addr;
              mem_wdata_q <= {DATA_W{1'b0}};
              streak_q    <= 4'd0;
            end
          end else begin
            state_q    <= IDLE;
            arb_busy_q <= 1'b0;
          end
        end
        BUSY: begin
          if (mem_ack) begin
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            if (arb_owner_q) begin
              ls_ack_q   <= 1'b1;
              ls_rdata_q <= mem_we_q ? {DATA_W{1'b0}} : mem_rdata;
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= mem_rdata;
            end
`ifdef ARB_TIMEOUT_EN
          end else if (tmo_q == TMO_LAST) begin
            // Abort: owner is still acked so the CPU sequencer never deadlocks.
            state_q   <= DONE;
            mem_req_q <= 1'b0;
            bus_err_q <= 1'b1;
            if (arb_owner_q) begin
              ls_ack_q   <= 1'b1;
              ls_rdata_q <= {DATA_W{1'b0}};
            end else begin
              if_ack_q   <= 1'b1;
              if_rdata_q <= {DATA_W{1'b0}};
            end
          end else begin
            tmo_q <= tmo_q + 8'd1;
          end
`else
          end else begin
            state_q <= BUSY;
          end
`endif
        end
        DONE: begin
          state_q    <= IDLE;
          if_ack_q   <= 1'b0;
          ls_ack_q   <= 1'b0;
          arb_busy_q <= 1'b0;
`ifdef ARB_TIMEOUT_EN
          bus_err_q  <= 1'b0;
`endif
        end
        default: begin
          state_q    <= IDLE;
          mem_req_q  <= 1'b0;
          if_ack_q   <= 1'b0;
          ls_ack_q   <= 1'b0;
          arb_busy_q <= 1'b0;
        end
      endcase
    end
  end

  assign if_ack    = if_ack_q;
  assign if_rdata  = if_rdata_q;
  assign ls_ack    = ls_ack_q;
  assign ls_rdata  = ls_rdata_q;
  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_wdata = mem_wdata_q;
  assign arb_busy  = arb_busy_q;
  assign arb_owner = arb_owner_q;

endmodule
